// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with count, thresholds, sticky errors, flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read data.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       we,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       re,
  output logic [DATA_W-1:0]          data_out,
  output logic                       dout_valid,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [CW-1:0]     cnt;
  logic              ovf_q;
  logic              unf_q;
  logic              wr_ok;
  logic              rd_ok;

  assign empty        = (cnt == '0);
  assign full         = (cnt == FULL_C);
  assign almost_empty = (cnt <= AE_C);
  assign almost_full  = (cnt >= AF_C);
  assign count        = cnt;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // clr wins over any access in the same cycle
  assign wr_ok = we & ~full & ~clr;
  assign rd_ok = re & ~empty & ~clr;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) rptr <= rptr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      unique case (1'b1)
        wr_ok & ~rd_ok: cnt <= cnt + CW'(1);
        rd_ok & ~wr_ok: cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (clr) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (we & full)  ovf_q <= 1'b1;
      if (re & empty) unf_q <= 1'b1;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN

  assign data_out   = empty ? '0 : mem[rptr];
  assign dout_valid = ~empty;

`else

  logic [DATA_W-1:0] dout_q;
  logic              dv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      dv_q   <= 1'b0;
    end else begin
      dv_q <= rd_ok;
      if (rd_ok) dout_q <= mem[rptr];
    end
  end

  assign data_out   = dout_q;
  assign dout_valid = dv_q;

`endif

endmodule
